ssp_ctx_engine: RTL and testbench
=================================

# ssp_ctx_engine

Exception-context push/pop engine that sits between the CP0 exception logic and `ssp_unit`. It drives the system stack pointer (SSP) from the consumer side: it reads the SSP and saves or restores a 3-word context frame (EPC, STATUS, CAUSE) through a memory handshake. It writes the updated SSP back only when the whole frame has transferred.

## Interface

Parameters:
- `SSP_LIMIT`, default 32'h0000_1000: lowest legal SSP byte address. Used only by the overflow check.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `push_req` in 1: exception entry; sampled in IDLE only.
- `pop_req` in 1: exception return (eret); sampled in IDLE only.
- `epc_in`, `status_in`, `cause_in` in 32 each: context to save. Sampled with `push_req`.
- `epc_out`, `status_out`, `cause_out` out 32 each: restored context. Registered; valid from `done` of a pop.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `stk_fault` out 1: one-cycle pulse on an overflow or underflow abort.
- `ssp_re` out 1: read enable to `ssp_unit` (`re_p`).
- `ssp_rdata` in 32: SSP value from `ssp_unit` (`read_data`).
- `ssp_we` out 1: write enable to `ssp_unit` (`we_s`).
- `ssp_wdata` out 32: new SSP value.
- `mem_req`, `mem_we` out 1: memory request and direction (1 = write).
- `mem_addr`, `mem_wdata` out 32: memory byte address and write data.
- `mem_rdata` in 32: memory read data.
- `mem_ack` in 1: beat accepted; read data valid in the same cycle.

## Operation

- States: IDLE, LOAD, XFER, COMMIT, plus FAULT (present only with the macro).
- IDLE:
  - `push_req` latches the inputs and the operation, then goes to LOAD.
  - `pop_req` latches the operation, then goes to LOAD.
  - If both are high in the same cycle, push wins and pop is dropped.
  - Requests arriving while `busy` is high are ignored; they are not queued.
- LOAD: `ssp_re` = 1 for one cycle. Snapshot S <= `ssp_rdata` at the end of that cycle. Next state is XFER, or FAULT if the check fails.
- XFER: beat index 0..2. The stack grows downward and all addresses are 32-bit modular (wrap-around silently when the check is compiled out).
  - Push writes EPC at S-4, STATUS at S-8, CAUSE at S-12 (`mem_we` = 1).
  - Pop reads CAUSE at S, STATUS at S+4, EPC at S+8 (`mem_we` = 0). `mem_rdata` is captured into the matching `*_out` register on `mem_ack`.
  - `mem_req` is held high with stable address and data until `mem_ack`. The next beat's address appears in the cycle after the ack, with `mem_req` remaining high.
  - After the beat-2 ack, go to COMMIT.
- COMMIT:
  - `ssp_we` = 1 and `done` = 1 for one cycle.
  - `ssp_wdata` = S-12 for a push, S+12 for a pop.
  - Then return to IDLE.
- FAULT: `stk_fault` = 1 for one cycle, then IDLE. No memory traffic and no SSP write occur.
- Reset mid-operation: return to IDLE with no SSP write. A partially written frame in memory is abandoned.

## Timing

- Reset values are 0 on every output, including `*_out`, `mem_addr` and `ssp_wdata`.
- Request-sampling edge is edge 0. Then:
  - LOAD occupies cycle 1.
  - With zero-wait `mem_ack`, XFER occupies cycles 2-4.
  - COMMIT/`done` is in cycle 5.
  - Each wait cycle on `mem_ack` adds one cycle.
- A new request can be accepted in the cycle after `done` or `stk_fault`.
- `epc_out`, `status_out` and `cause_out` hold their value until the next pop overwrites them; a push leaves them unchanged.

## Configuration

- `SSP_OVERFLOW_CHECK_EN` defined:
  - Push faults if S-12 < `SSP_LIMIT` (unsigned, including borrow).
  - Pop faults if S > 32'hFFFF_FFF3 (S+12 would wrap).
  - A fault goes LOAD -> FAULT.
- Not defined:
  - FAULT state is absent; LOAD always goes to XFER.
  - `stk_fault` is tied to 0.
  - Addresses wrap modulo 2^32.

## Structure

- Shared header `head.v` holds:
  - `ENABLE`/`DISABLE`.
  - State encodings (`CTX_IDLE`..`CTX_FAULT`).
  - `CTX_FRAME_BYTES` = 12.
- One sub-module, `ctx_addr_gen`, is used: a combinational offset/address generator (S, op, beat index) -> `mem_addr`, plus the next-SSP value.

## Test plan

- Push: SSP = 32'h0000_2000, EPC/STATUS/CAUSE = 11/22/33, zero-wait ack.
  - Required: writes 11@1FFC, 22@1FF8, 33@1FF4.
  - `ssp_we` with 32'h0000_1FF4 and `done` in cycle 5.
- Pop, from memory holding that frame, SSP = 32'h0000_1FF4.
  - Required: reads 1FF4, 1FF8, 1FFC.
  - `cause_out`=33, `status_out`=22, `epc_out`=11.
  - SSP write 32'h0000_2000.
- Push with two wait cycles on every beat.
  - Required: `mem_addr` and `mem_wdata` stable while waiting.
  - `done` in cycle 11.
- `push_req` and `pop_req` asserted together, followed by a `pop_req` while busy.
  - Required: exactly one push executes and the pop is ignored.
- Assert `rst` during beat 1 of a push.
  - Required: all outputs 0 immediately, `ssp_we` never pulses, and the next push works.
- With `SSP_OVERFLOW_CHECK_EN` defined: push at SSP = 32'h0000_1008 with `SSP_LIMIT` = 32'h1000.
  - Required: `stk_fault` pulse in cycle 2, no `mem_req`, no `ssp_we`.

Source files
------------

// File: rtl/ssp_ctx_engine_pkg.sv
// Shared types and constants for the exception-context push/pop engine.
// SSP_OVERFLOW_CHECK_EN adds the FAULT state and the frame-bounds check.
package ssp_ctx_engine_pkg;

   localparam int unsigned DATA_W          = 32;
   localparam int unsigned BEAT_W          = 2;
   localparam int unsigned WORD_BYTES      = 4;
   localparam int unsigned CTX_FRAME_BYTES = 12;
   localparam int unsigned LAST_BEAT       = 2;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   typedef enum logic [2:0] {
      CTX_IDLE   = 3'd0,
      CTX_LOAD   = 3'd1,
      CTX_XFER   = 3'd2,
      CTX_COMMIT = 3'd3
`ifdef SSP_OVERFLOW_CHECK_EN
      ,
      CTX_FAULT  = 3'd4
`endif
   } ctx_state_e;

   typedef enum logic {
      OP_PUSH = 1'b0,
      OP_POP  = 1'b1
   } ctx_op_e;

   typedef struct packed {
      logic [DATA_W-1:0] epc;
      logic [DATA_W-1:0] status;
      logic [DATA_W-1:0] cause;
   } ctx_frame_t;

`ifdef SSP_OVERFLOW_CHECK_EN
   // A push must leave S-12 at or above the limit without borrowing; a pop must not wrap S+12.
   function automatic logic frame_fault(input ctx_op_e op, input logic [DATA_W-1:0] s,
                                        input logic [DATA_W-1:0] limit);
      logic [DATA_W-1:0] low;
      low = s - DATA_W'(CTX_FRAME_BYTES);
      if (op == OP_PUSH) return (s < DATA_W'(CTX_FRAME_BYTES)) || (low < limit);
      return s > 32'hFFFF_FFF3;
   endfunction
`endif

endpackage

// File: rtl/ssp_ctx_engine_if.sv
// SSP-unit and memory handshake bundle between the context engine and its neighbours.
import ssp_ctx_engine_pkg::*;

interface ssp_ctx_engine_if;
   logic              ssp_re;
   logic [DATA_W-1:0] ssp_rdata;
   logic              ssp_we;
   logic [DATA_W-1:0] ssp_wdata;
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output ssp_re, ssp_we, ssp_wdata, mem_req, mem_we, mem_addr, mem_wdata,
      input  ssp_rdata, mem_rdata, mem_ack
   );

   modport slave (
      input  ssp_re, ssp_we, ssp_wdata, mem_req, mem_we, mem_addr, mem_wdata,
      output ssp_rdata, mem_rdata, mem_ack
   );
endinterface

// File: rtl/ssp_ctx_engine_ctx_addr_gen.sv
// Frame address and next-SSP generator: push walks down from S-4, pop walks up from S.
import ssp_ctx_engine_pkg::*;

module ctx_addr_gen (
   input  logic [DATA_W-1:0] ssp,
   input  ctx_op_e           op,
   input  logic [BEAT_W-1:0] beat,
   output logic [DATA_W-1:0] addr_c,
   output logic [DATA_W-1:0] next_ssp_c
);
   logic [DATA_W-1:0] offset;

   always_comb begin
      offset = DATA_W'({beat, 2'b00});
      if (op == OP_PUSH) begin
         addr_c     = ssp - DATA_W'(WORD_BYTES) - offset;
         next_ssp_c = ssp - DATA_W'(CTX_FRAME_BYTES);
      end else begin
         addr_c     = ssp + offset;
         next_ssp_c = ssp + DATA_W'(CTX_FRAME_BYTES);
      end
   end
endmodule

// File: rtl/ssp_ctx_engine.sv
// Exception-context push/pop engine: saves/restores EPC, STATUS, CAUSE on the SSP stack.
// SSP_OVERFLOW_CHECK_EN enables the SSP_LIMIT / wrap check and the stk_fault pulse.
import ssp_ctx_engine_pkg::*;

module ssp_ctx_engine #(
   parameter logic [31:0] SSP_LIMIT = 32'h0000_1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_req,
   input  logic              pop_req,
   input  logic [DATA_W-1:0] epc_in,
   input  logic [DATA_W-1:0] status_in,
   input  logic [DATA_W-1:0] cause_in,
   output logic [DATA_W-1:0] epc_out,
   output logic [DATA_W-1:0] status_out,
   output logic [DATA_W-1:0] cause_out,
   output logic              busy,
   output logic              done,
   output logic              stk_fault,
   ssp_ctx_engine_if.master  bus
);
   ctx_state_e        state_q, state_d;
   ctx_op_e           op_q, op_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [DATA_W-1:0] snap_q, snap_d;
   ctx_frame_t        frame_q, frame_d;

   logic              busy_q, busy_d, done_q, done_d;
   logic              ssp_re_q, ssp_re_d, ssp_we_q, ssp_we_d;
   logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [DATA_W-1:0] ssp_wdata_q, ssp_wdata_d, mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] epc_out_q, epc_out_d, status_out_q, status_out_d;
   logic [DATA_W-1:0] cause_out_q, cause_out_d;
   logic [DATA_W-1:0] addr_c, next_ssp_c;

   // Address generation looks at next-cycle state so the registered address lines up with mem_req.
   ctx_addr_gen u_addr_gen (
      .ssp        (snap_d),
      .op         (op_d),
      .beat       (beat_d),
      .addr_c     (addr_c),
      .next_ssp_c (next_ssp_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= CTX_IDLE;
         op_q         <= OP_PUSH;
         beat_q       <= '0;
         snap_q       <= '0;
         frame_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ssp_re_q     <= 1'b0;
         ssp_we_q     <= 1'b0;
         ssp_wdata_q  <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         epc_out_q    <= '0;
         status_out_q <= '0;
         cause_out_q  <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         beat_q       <= beat_d;
         snap_q       <= snap_d;
         frame_q      <= frame_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ssp_re_q     <= ssp_re_d;
         ssp_we_q     <= ssp_we_d;
         ssp_wdata_q  <= ssp_wdata_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         epc_out_q    <= epc_out_d;
         status_out_q <= status_out_d;
         cause_out_q  <= cause_out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      beat_d  = beat_q;
      snap_d  = snap_q;
      frame_d = frame_q;
      case (state_q)
         CTX_IDLE: begin
            if (push_req) begin
               state_d = CTX_LOAD;
               op_d    = OP_PUSH;
               frame_d = '{epc: epc_in, status: status_in, cause: cause_in};
            end else if (pop_req) begin
               state_d = CTX_LOAD;
               op_d    = OP_POP;
            end
         end
         CTX_LOAD: begin
            snap_d  = bus.ssp_rdata;
            beat_d  = '0;
            state_d = CTX_XFER;
`ifdef SSP_OVERFLOW_CHECK_EN
            if (frame_fault(op_q, bus.ssp_rdata, SSP_LIMIT)) state_d = CTX_FAULT;
`endif
         end
         CTX_XFER: begin
            if (bus.mem_ack) begin
               if (beat_q == BEAT_W'(LAST_BEAT)) state_d = CTX_COMMIT;
               else                              beat_d  = beat_q + BEAT_W'(1);
            end
         end
         CTX_COMMIT: state_d = CTX_IDLE;
`ifdef SSP_OVERFLOW_CHECK_EN
         CTX_FAULT:  state_d = CTX_IDLE;
`endif
         default:    state_d = CTX_IDLE;
      endcase
   end

   always_comb begin
      busy_d       = (state_d != CTX_IDLE);
      done_d       = (state_d == CTX_COMMIT);
      ssp_re_d     = (state_d == CTX_LOAD);
      ssp_we_d     = (state_d == CTX_COMMIT);
      mem_req_d    = (state_d == CTX_XFER);
      mem_we_d     = (state_d == CTX_XFER) && (op_d == OP_PUSH);
      ssp_wdata_d  = ssp_wdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      epc_out_d    = epc_out_q;
      status_out_d = status_out_q;
      cause_out_d  = cause_out_q;
      if (state_d == CTX_XFER) begin
         mem_addr_d = addr_c;
         if (op_d == OP_PUSH) begin
            case (beat_d)
               2'd0:    mem_wdata_d = frame_d.epc;
               2'd1:    mem_wdata_d = frame_d.status;
               default: mem_wdata_d = frame_d.cause;
            endcase
         end
      end
      if (state_d == CTX_COMMIT) ssp_wdata_d = next_ssp_c;
      // Pop beats arrive CAUSE, STATUS, EPC in ascending address order.
      if (state_q == CTX_XFER && op_q == OP_POP && bus.mem_ack) begin
         case (beat_q)
            2'd0:    cause_out_d  = bus.mem_rdata;
            2'd1:    status_out_d = bus.mem_rdata;
            default: epc_out_d    = bus.mem_rdata;
         endcase
      end
   end

`ifdef SSP_OVERFLOW_CHECK_EN
   logic fault_q, fault_d;

   always_comb fault_d = (state_d == CTX_FAULT) ? ENABLE : DISABLE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fault_q <= 1'b0;
      else     fault_q <= fault_d;
   end

   assign stk_fault = fault_q;
`else
   logic unused_limit_c;
   assign unused_limit_c = ^SSP_LIMIT;
   assign stk_fault      = DISABLE;
`endif

   assign busy          = busy_q;
   assign done          = done_q;
   assign epc_out       = epc_out_q;
   assign status_out    = status_out_q;
   assign cause_out     = cause_out_q;
   assign bus.ssp_re    = ssp_re_q;
   assign bus.ssp_we    = ssp_we_q;
   assign bus.ssp_wdata = ssp_wdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_ssp_ctx_engine.sv
// Bench for ssp_ctx_engine: directed plan steps plus a random push/pop stack walk against a frame model.
module tb_ssp_ctx_engine;
   logic        clk = 1'b0;
   logic        rst;
   logic        push_req, pop_req;
   logic [31:0] epc_in, status_in, cause_in;
   logic [31:0] epc_out, status_out, cause_out;
   logic        busy, done, stk_fault;

   always #5 clk = ~clk;

   ssp_ctx_engine_if bus ();

   ssp_ctx_engine #(.SSP_LIMIT(32'h0000_1000)) dut (
      .clk        (clk),
      .rst        (rst),
      .push_req   (push_req),
      .pop_req    (pop_req),
      .epc_in     (epc_in),
      .status_in  (status_in),
      .cause_in   (cause_in),
      .epc_out    (epc_out),
      .status_out (status_out),
      .cause_out  (cause_out),
      .busy       (busy),
      .done       (done),
      .stk_fault  (stk_fault),
      .bus        (bus)
   );

   // Environment: SSP register, 16 KB word memory window, and activity counters.
   logic [31:0] ssp_reg = 32'h0;
   logic        ssp_load = 1'b0;
   logic [31:0] ssp_set = 32'h0;
   logic [31:0] tbmem [0:4095];
   int          waits = 0;
   int          wcnt = 0;
   int          n_ssp_we = 0, n_done = 0, n_fault = 0, n_req = 0;
   int          stab_viol = 0, stab_checks = 0;
   logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
   logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;
   logic [31:0] wr_log [$];
   logic [31:0] rd_log [$];

   assign bus.ssp_rdata = ssp_reg;
   assign bus.mem_ack   = bus.mem_req && (wcnt == waits);
   assign bus.mem_rdata = tbmem[bus.mem_addr[13:2]];

   always @(posedge clk) begin
      if (ssp_load)        ssp_reg <= ssp_set;
      else if (bus.ssp_we) ssp_reg <= bus.ssp_wdata;
      if (bus.ssp_we) n_ssp_we <= n_ssp_we + 1;
      if (done)       n_done   <= n_done + 1;
      if (stk_fault)  n_fault  <= n_fault + 1;
      if (bus.mem_req) n_req   <= n_req + 1;
      if (bus.mem_req && bus.mem_ack) begin
         wcnt <= 0;
         if (bus.mem_we) begin
            tbmem[bus.mem_addr[13:2]] <= bus.mem_wdata;
            wr_log.push_back(bus.mem_addr);
         end else begin
            rd_log.push_back(bus.mem_addr);
         end
      end else if (bus.mem_req) wcnt <= wcnt + 1;
      else                      wcnt <= 0;
      if (prev_req && !prev_ack && bus.mem_req) begin
         stab_checks <= stab_checks + 1;
         if (bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_wdata || bus.mem_we !== prev_we)
            stab_viol <= stab_viol + 1;
      end
      prev_req   <= bus.mem_req;
      prev_ack   <= bus.mem_ack;
      prev_we    <= bus.mem_we;
      prev_addr  <= bus.mem_addr;
      prev_wdata <= bus.mem_wdata;
   end

   // Reference model: the stack as an addressed word array plus the SSP and restored context.
   logic [31:0] m_mem [0:4095];
   logic [31:0] m_ssp;
   logic [31:0] m_epc, m_status, m_cause;
   int          n_cmp = 0, n_bad = 0;

   function automatic logic [11:0] idx(input logic [31:0] a);
      return a[13:2];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_ssp(input logic [31:0] v);
      @(posedge clk); #1;
      ssp_load = 1'b1; ssp_set = v;
      @(posedge clk); #1;
      ssp_load = 1'b0;
      m_ssp = v;
   endtask

   task automatic run_op(input logic p, input logic q, input logic [31:0] e, s, c,
                         output int cyc, output logic flt, output logic re1, output logic [31:0] wd);
      @(posedge clk); #1;
      push_req = p; pop_req = q; epc_in = e; status_in = s; cause_in = c;
      @(posedge clk); #1;
      push_req = 1'b0; pop_req = 1'b0;
      cyc = 1; re1 = bus.ssp_re;
      while (!(done || stk_fault) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      flt = stk_fault;
      wd  = bus.ssp_wdata;
      if (cyc >= 200) cyc = -1;
   endtask

   task automatic do_push(input logic [31:0] e, s, c, input int w);
      int cyc, base; logic flt, re1; logic [31:0] wd, sp;
      logic [31:0] exp_addr [3];
      sp = m_ssp; waits = w; base = wr_log.size();
      run_op(1'b1, 1'b0, e, s, c, cyc, flt, re1, wd);
      chk("push_done_cycle", 32'(cyc), 32'(5 + 3 * w));
      chk("push_ssp_re_cycle1", 32'(re1), 32'd1);
      chk("push_no_fault", 32'(flt), 32'd0);
      chk("push_ssp_wdata", wd, sp - 32'd12);
      m_mem[idx(sp - 32'd4)] = e; m_mem[idx(sp - 32'd8)] = s; m_mem[idx(sp - 32'd12)] = c;
      m_ssp = sp - 32'd12;
      exp_addr[0] = sp - 32'd4; exp_addr[1] = sp - 32'd8; exp_addr[2] = sp - 32'd12;
      @(posedge clk); #1;
      chk("push_ssp", ssp_reg, m_ssp);
      chk("push_nwrites", 32'(wr_log.size() - base), 32'd3);
      for (int k = 0; k < 3; k++) begin
         if (base + k < wr_log.size()) chk("push_addr", wr_log[base + k], exp_addr[k]);
         chk("push_mem", tbmem[idx(exp_addr[k])], m_mem[idx(exp_addr[k])]);
      end
      chk("push_keeps_epc_out", epc_out, m_epc);
      chk("push_keeps_cause_out", cause_out, m_cause);
   endtask

   task automatic do_pop(input int w);
      int cyc, base; logic flt, re1; logic [31:0] wd, sp;
      sp = m_ssp; waits = w; base = rd_log.size();
      run_op(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, cyc, flt, re1, wd);
      m_cause = m_mem[idx(sp)]; m_status = m_mem[idx(sp + 32'd4)]; m_epc = m_mem[idx(sp + 32'd8)];
      m_ssp = sp + 32'd12;
      chk("pop_done_cycle", 32'(cyc), 32'(5 + 3 * w));
      chk("pop_no_fault", 32'(flt), 32'd0);
      chk("pop_ssp_wdata", wd, m_ssp);
      chk("pop_cause_out", cause_out, m_cause);
      chk("pop_status_out", status_out, m_status);
      chk("pop_epc_out", epc_out, m_epc);
      @(posedge clk); #1;
      chk("pop_ssp", ssp_reg, m_ssp);
      chk("pop_nreads", 32'(rd_log.size() - base), 32'd3);
      for (int k = 0; k < 3; k++)
         if (base + k < rd_log.size()) chk("pop_addr", rd_log[base + k], sp + 32'(4 * k));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int depth, nd, nw, nr, nwe, cnt;
      logic [31:0] sp;
      rst = 1'b1; push_req = 1'b0; pop_req = 1'b0;
      epc_in = '0; status_in = '0; cause_in = '0;
      for (int i = 0; i < 4096; i++) m_mem[i] = 32'h0;
      m_ssp = 32'h0; m_epc = 32'h0; m_status = 32'h0; m_cause = 32'h0;
      #12;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_mem_req", 32'(bus.mem_req), 32'd0);
      chk("reset_mem_addr", bus.mem_addr, 32'd0);
      chk("reset_ssp_wdata", bus.ssp_wdata, 32'd0);
      chk("reset_epc_out", epc_out, 32'd0);
      @(posedge clk); #1; rst = 1'b0;

      // Plan: push 11/22/33 at 0x2000, then pop it back from 0x1FF4.
      set_ssp(32'h0000_2000);
      do_push(32'd11, 32'd22, 32'd33, 0);
      chk("plan_push_ssp", ssp_reg, 32'h0000_1FF4);
      chk("plan_mem_1ffc", tbmem[idx(32'h1FFC)], 32'd11);
      chk("plan_mem_1ff4", tbmem[idx(32'h1FF4)], 32'd33);
      do_pop(0);
      chk("plan_pop_epc", epc_out, 32'd11);
      chk("plan_pop_status", status_out, 32'd22);
      chk("plan_pop_cause", cause_out, 32'd33);
      chk("plan_pop_ssp", ssp_reg, 32'h0000_2000);

      // Two wait cycles per beat: done in cycle 11, bus held stable.
      do_push(32'h44, 32'h55, 32'h66, 2);
      chk("wait_stable_exercised", 32'(stab_checks > 0), 32'd1);
      do_pop(1);

      // Simultaneous push/pop then pop while busy: one push only.
      sp = m_ssp; waits = 0; nd = n_done; nw = wr_log.size(); nr = rd_log.size();
      @(posedge clk); #1;
      push_req = 1'b1; pop_req = 1'b1; epc_in = 32'hA1; status_in = 32'hA2; cause_in = 32'hA3;
      @(posedge clk); #1;
      push_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 pop_req = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      m_mem[idx(sp - 32'd4)] = 32'hA1; m_mem[idx(sp - 32'd8)] = 32'hA2; m_mem[idx(sp - 32'd12)] = 32'hA3;
      m_ssp = sp - 32'd12;
      chk("both_ndone", 32'(n_done - nd), 32'd1);
      chk("both_nwrites", 32'(wr_log.size() - nw), 32'd3);
      chk("both_nreads", 32'(rd_log.size() - nr), 32'd0);
      chk("both_ssp", ssp_reg, m_ssp);
      chk("both_idle", 32'(busy), 32'd0);

      // Reset during beat 1 of a push.
      sp = m_ssp; waits = 2; nwe = n_ssp_we; cnt = 0;
      @(posedge clk); #1;
      push_req = 1'b1; epc_in = 32'hB1; status_in = 32'hB2; cause_in = 32'hB3;
      @(posedge clk); #1;
      push_req = 1'b0;
      while (!(bus.mem_req && bus.mem_addr == sp - 32'd8) && cnt < 50) begin
         @(posedge clk); #1; cnt++;
      end
      chk("rst_reached_beat1", bus.mem_addr, sp - 32'd8);
      rst = 1'b1; #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_req_we", {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_ssp_ctl", {29'd0, bus.ssp_re, bus.ssp_we, done}, 32'd0);
      chk("rst_ssp_wdata", bus.ssp_wdata, 32'd0);
      chk("rst_outs", epc_out | status_out | cause_out, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_no_ssp_we", 32'(n_ssp_we - nwe), 32'd0);
      chk("rst_ssp_unchanged", ssp_reg, sp);
      m_mem[idx(sp - 32'd4)] = 32'hB1;
      m_epc = 32'h0; m_status = 32'h0; m_cause = 32'h0;
      do_push(32'hC1, 32'hC2, 32'hC3, 0);
      do_pop(0);

`ifdef SSP_OVERFLOW_CHECK_EN
      begin
         int cyc; logic flt, re1; logic [31:0] wd;
         set_ssp(32'h0000_1008);
         nd = n_req; nwe = n_ssp_we; waits = 0;
         run_op(1'b1, 1'b0, 32'h1, 32'h2, 32'h3, cyc, flt, re1, wd);
         chk("ovf_fault_cycle", 32'(cyc), 32'd2);
         chk("ovf_fault_pulse", 32'(flt), 32'd1);
         @(posedge clk); #1;
         chk("ovf_no_mem_req", 32'(n_req - nd), 32'd0);
         chk("ovf_no_ssp_we", 32'(n_ssp_we - nwe), 32'd0);
         chk("ovf_ssp", ssp_reg, 32'h0000_1008);
         set_ssp(32'hFFFF_FFF8);
         run_op(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, cyc, flt, re1, wd);
         chk("unf_fault_cycle", 32'(cyc), 32'd2);
         chk("unf_fault_pulse", 32'(flt), 32'd1);
         set_ssp(32'h0000_100C);
         do_push(32'hD1, 32'hD2, 32'hD3, 0);
         chk("limit_edge_ssp", ssp_reg, 32'h0000_1000);
      end
`else
      // Unchecked build: addresses wrap through zero.
      set_ssp(32'h0000_0008);
      do_push(32'hE1, 32'hE2, 32'hE3, 1);
      chk("wrap_ssp", ssp_reg, 32'hFFFF_FFFC);
      do_pop(0);
      chk("wrap_pop_epc", epc_out, 32'hE1);
      chk("no_fault_ever", 32'(n_fault), 32'd0);
`endif

      // Random stack walk.
      set_ssp(32'h0000_2000 + 32'(4 * $urandom_range(0, 1023)));
      depth = 0;
      for (int i = 0; i < 40; i++) begin
         if (depth == 0 || (depth < 6 && ($urandom % 2) == 0)) begin
            do_push($urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
            depth++;
         end else begin
            do_pop(int'($urandom_range(0, 3)));
            depth--;
         end
      end

      chk("bus_stable_while_waiting", 32'(stab_viol), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
